// File: rtl/netwalk_meter_band_checker.sv
// Per-flow threshold checker behind the flow meter: flags counts at/over a programmable band, queues first-crossing events.
// Latency: exceed_* outputs register one cycle after the qualified update; event FIFO is first-word fall-through.
// Backpressure: evt_ready stalls the event FIFO only; meter updates never stall, and events that find the FIFO full are dropped and counted.
//
// Ports:
//   clk, reset                 - rising-edge clock, synchronous active-low reset
//   glbl_program_en            - global programming window; meter updates ignored while high
//   band_program_enable/_delete_enable/_addr/_data - threshold table write (delete forces 0)
//   meter_count/_valid/_addr   - per-flow count update from the meter stage
//   exceed_valid/_flag/_addr   - registered compare result toward the action stage
//   evt_valid/evt_ready/evt_addr/evt_count - crossing-event FIFO head, valid/ready drained
//   evt_drop_count             - saturating count of events lost to a full FIFO
module netwalk_meter_band_checker #(
    parameter int TCAM_ADDR_WIDTH    = 6,
    parameter int METER_COUNTER_SIZE = 32,
    parameter int EVT_FIFO_AW        = 3,
    parameter int DROP_CNT_WIDTH     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          glbl_program_en,
    input  logic                          band_program_enable,
    input  logic                          band_delete_enable,
    input  logic [TCAM_ADDR_WIDTH-1:0]    band_program_addr,
    input  logic [METER_COUNTER_SIZE-1:0] band_program_data,
    input  logic [METER_COUNTER_SIZE-1:0] meter_count,
    input  logic                          meter_count_valid,
    input  logic [TCAM_ADDR_WIDTH-1:0]    meter_count_addr,
    output logic                          exceed_valid,
    output logic                          exceed_flag,
    output logic [TCAM_ADDR_WIDTH-1:0]    exceed_addr,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [TCAM_ADDR_WIDTH-1:0]    evt_addr,
    output logic [METER_COUNTER_SIZE-1:0] evt_count,
    output logic [DROP_CNT_WIDTH-1:0]     evt_drop_count
);

    localparam int TBL_DEPTH = 1 << TCAM_ADDR_WIDTH;
    localparam int EVT_DEPTH = 1 << EVT_FIFO_AW;
    localparam logic [EVT_FIFO_AW:0] LP_EVT_FULL = {1'b1, {EVT_FIFO_AW{1'b0}}};

    // Threshold table and per-flow "event already raised" bits.
    logic [METER_COUNTER_SIZE-1:0] r_thr [TBL_DEPTH];
    logic [TBL_DEPTH-1:0]          r_reported;

    // Registered compare result.
    logic                          r_exceed_valid;
    logic                          r_exceed_flag;
    logic [TCAM_ADDR_WIDTH-1:0]    r_exceed_addr;

    // Event FIFO: storage, pointers and an occupancy counter for full/empty.
    logic [TCAM_ADDR_WIDTH-1:0]    r_fifo_addr [EVT_DEPTH];
    logic [METER_COUNTER_SIZE-1:0] r_fifo_cnt  [EVT_DEPTH];
    logic [EVT_FIFO_AW-1:0]        r_wr_ptr;
    logic [EVT_FIFO_AW-1:0]        r_rd_ptr;
    logic [EVT_FIFO_AW:0]          r_occ;
    logic [DROP_CNT_WIDTH-1:0]     r_drop_cnt;

    logic                          w_q;
    logic [METER_COUNTER_SIZE-1:0] w_thr;
    logic                          w_hit;
    logic                          w_new_evt;
    logic                          w_empty;
    logic                          w_full;
    logic                          w_pop;
    logic                          w_push;
    logic                          w_drop;

    assign w_q   = meter_count_valid && !glbl_program_en;
    // Combinational table read; a same-cycle program write is not yet visible,
    // so a colliding update compares against the old threshold.
    assign w_thr = r_thr[meter_count_addr];
    assign w_hit = (w_thr != '0) && (meter_count >= w_thr);

    assign w_new_evt = w_q && w_hit && !r_reported[meter_count_addr];
    assign w_empty   = (r_occ == '0);
    assign w_full    = (r_occ == LP_EVT_FULL);
    assign w_pop     = !w_empty && evt_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign w_push    = w_new_evt && (!w_full || w_pop);
    assign w_drop    = w_new_evt && !w_push;

    // Threshold table and reported bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                r_thr[i] <= '0;
            end
            r_reported <= '0;
        end else begin
            if (w_push) begin
                r_reported[meter_count_addr] <= 1'b1;
            end
            // Written after the set so a reprogram of the same flow clears it.
            if (band_program_enable) begin
                r_thr[band_program_addr]      <= band_delete_enable ? '0 : band_program_data;
                r_reported[band_program_addr] <= 1'b0;
            end
        end
    end

    // Compare result, one cycle after the update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_exceed_valid <= 1'b0;
            r_exceed_flag  <= 1'b0;
            r_exceed_addr  <= '0;
        end else begin
            r_exceed_valid <= w_q;
            r_exceed_flag  <= w_q && w_hit;
            r_exceed_addr  <= w_q ? meter_count_addr : '0;
        end
    end

    // FIFO control and drop counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + EVT_FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + EVT_FIFO_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + (EVT_FIFO_AW + 1)'(1);
                2'b01:   r_occ <= r_occ - (EVT_FIFO_AW + 1)'(1);
                default: r_occ <= r_occ;
            endcase
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + DROP_CNT_WIDTH'(1);
            end
        end
    end

    // FIFO storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= meter_count_addr;
            r_fifo_cnt[r_wr_ptr]  <= meter_count;
        end
    end

    assign exceed_valid   = r_exceed_valid;
    assign exceed_flag    = r_exceed_flag;
    assign exceed_addr    = r_exceed_addr;
    assign evt_valid      = !w_empty;
    assign evt_addr       = w_empty ? '0 : r_fifo_addr[r_rd_ptr];
    assign evt_count      = w_empty ? '0 : r_fifo_cnt[r_rd_ptr];
    assign evt_drop_count = r_drop_cnt;

endmodule

// File: tb/tb_netwalk_meter_band_checker.sv
// Bench for netwalk_meter_band_checker: vector table, directed corner sequences, random traffic vs a reference model.
// Latency: outputs compared 1 time unit after each rising edge.
// Backpressure: evt_ready is driven by the stimulus (held low to fill the FIFO, random later).
module tb_netwalk_meter_band_checker;

    logic        clk;
    logic        reset;
    logic        glbl_program_en;
    logic        band_program_enable;
    logic        band_delete_enable;
    logic [5:0]  band_program_addr;
    logic [31:0] band_program_data;
    logic [31:0] meter_count;
    logic        meter_count_valid;
    logic [5:0]  meter_count_addr;
    logic        exceed_valid;
    logic        exceed_flag;
    logic [5:0]  exceed_addr;
    logic        evt_valid;
    logic        evt_ready;
    logic [5:0]  evt_addr;
    logic [31:0] evt_count;
    logic [15:0] evt_drop_count;

    netwalk_meter_band_checker dut (
        .clk                 (clk),
        .reset               (reset),
        .glbl_program_en     (glbl_program_en),
        .band_program_enable (band_program_enable),
        .band_delete_enable  (band_delete_enable),
        .band_program_addr   (band_program_addr),
        .band_program_data   (band_program_data),
        .meter_count         (meter_count),
        .meter_count_valid   (meter_count_valid),
        .meter_count_addr    (meter_count_addr),
        .exceed_valid        (exceed_valid),
        .exceed_flag         (exceed_flag),
        .exceed_addr         (exceed_addr),
        .evt_valid           (evt_valid),
        .evt_ready           (evt_ready),
        .evt_addr            (evt_addr),
        .evt_count           (evt_count),
        .evt_drop_count      (evt_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // Reference model state: thresholds, reported flags, event queue, drop count.
    logic [31:0] m_thr [64];
    bit          m_rep [64];
    logic [5:0]  qa [$];
    logic [31:0] qc [$];
    int          m_drop;
    logic        e_valid;
    logic        e_flag;
    logic [5:0]  e_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        glbl_program_en     = 1'b0;
        band_program_enable = 1'b0;
        band_delete_enable  = 1'b0;
        band_program_addr   = '0;
        band_program_data   = '0;
        meter_count_valid   = 1'b0;
        meter_count         = '0;
        meter_count_addr    = '0;
    endtask

    task automatic set_prog(input logic [5:0] a, input logic [31:0] d);
        band_program_enable = 1'b1;
        band_delete_enable  = 1'b0;
        band_program_addr   = a;
        band_program_data   = d;
    endtask

    task automatic set_meter(input logic [5:0] a, input logic [31:0] c);
        meter_count_valid = 1'b1;
        meter_count_addr  = a;
        meter_count       = c;
    endtask

    // Advance the model by the rules for the current inputs, clock once, compare everything.
    task automatic tick();
        bit          pop;
        bit          q;
        bit          hit;
        logic [31:0] t;
        if (!reset) begin
            for (int i = 0; i < 64; i++) begin
                m_thr[i] = '0;
                m_rep[i] = 1'b0;
            end
            qa.delete();
            qc.delete();
            m_drop  = 0;
            e_valid = 1'b0;
            e_flag  = 1'b0;
            e_addr  = '0;
        end else begin
            pop     = (qa.size() > 0) && evt_ready;
            q       = meter_count_valid && !glbl_program_en;
            t       = m_thr[meter_count_addr];
            hit     = (t != 0) && (meter_count >= t);
            e_valid = q;
            e_flag  = q && hit;
            e_addr  = q ? meter_count_addr : 6'd0;
            if (pop) begin
                void'(qa.pop_front());
                void'(qc.pop_front());
            end
            if (q && hit && !m_rep[meter_count_addr]) begin
                if (qa.size() < 8) begin
                    qa.push_back(meter_count_addr);
                    qc.push_back(meter_count);
                    m_rep[meter_count_addr] = 1'b1;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end
            if (band_program_enable) begin
                m_thr[band_program_addr] = band_delete_enable ? 32'd0 : band_program_data;
                m_rep[band_program_addr] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("exceed_valid", 64'(exceed_valid), 64'(e_valid));
        chk("exceed_flag", 64'(exceed_flag), 64'(e_flag));
        chk("exceed_addr", 64'(exceed_addr), 64'(e_addr));
        chk("evt_valid", 64'(evt_valid), 64'(qa.size() != 0));
        chk("evt_addr", 64'(evt_addr), (qa.size() != 0) ? 64'(qa[0]) : 64'd0);
        chk("evt_count", 64'(evt_count), (qc.size() != 0) ? 64'(qc[0]) : 64'd0);
        chk("evt_drop_count", 64'(evt_drop_count), 64'(m_drop));
    endtask

    typedef struct {
        logic        prog;
        logic        del;
        logic [5:0]  paddr;
        logic [31:0] pdata;
        logic        mv;
        logic        glbl;
        logic [5:0]  maddr;
        logic [31:0] mcnt;
        logic        rdy;
        logic        ev;
        logic        ef;
        logic [5:0]  ea;
        logic        evv;
    } vec_t;

    vec_t vt [13];

    initial begin
        tests = 0;
        fails = 0;
        set_idle();
        evt_ready = 1'b0;
        reset     = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        chk("reset_exceed_valid", 64'(exceed_valid), 64'd0);
        chk("reset_evt_valid", 64'(evt_valid), 64'd0);
        chk("reset_drop", 64'(evt_drop_count), 64'd0);

        // Basic threshold walk, delete, and the global programming window.
        //            prog  del   paddr  pdata   mv    glbl  maddr  mcnt     rdy   ev    ef    ea     evv
        vt[0]  = '{1'b1, 1'b0, 6'd5,  32'd3, 1'b0, 1'b0, 6'd0,  32'd0,   1'b1, 1'b0, 1'b0, 6'd0,  1'b0};
        vt[1]  = '{1'b0, 1'b0, 6'd0,  32'd0, 1'b1, 1'b0, 6'd5,  32'd1,   1'b1, 1'b1, 1'b0, 6'd5,  1'b0};
        vt[2]  = '{1'b0, 1'b0, 6'd0,  32'd0, 1'b1, 1'b0, 6'd5,  32'd2,   1'b1, 1'b1, 1'b0, 6'd5,  1'b0};
        vt[3]  = '{1'b0, 1'b0, 6'd0,  32'd0, 1'b1, 1'b0, 6'd5,  32'd3,   1'b1, 1'b1, 1'b1, 6'd5,  1'b1};
        vt[4]  = '{1'b0, 1'b0, 6'd0,  32'd0, 1'b1, 1'b0, 6'd5,  32'd4,   1'b1, 1'b1, 1'b1, 6'd5,  1'b0};
        vt[5]  = '{1'b0, 1'b0, 6'd0,  32'd0, 1'b0, 1'b0, 6'd0,  32'd0,   1'b1, 1'b0, 1'b0, 6'd0,  1'b0};
        vt[6]  = '{1'b1, 1'b0, 6'd2,  32'd1, 1'b0, 1'b0, 6'd0,  32'd0,   1'b1, 1'b0, 1'b0, 6'd0,  1'b0};
        vt[7]  = '{1'b1, 1'b1, 6'd2,  32'd7, 1'b0, 1'b0, 6'd0,  32'd0,   1'b1, 1'b0, 1'b0, 6'd0,  1'b0};
        vt[8]  = '{1'b0, 1'b0, 6'd0,  32'd0, 1'b1, 1'b0, 6'd2,  32'd100, 1'b1, 1'b1, 1'b0, 6'd2,  1'b0};
        vt[9]  = '{1'b1, 1'b0, 6'd11, 32'd5, 1'b0, 1'b0, 6'd0,  32'd0,   1'b1, 1'b0, 1'b0, 6'd0,  1'b0};
        vt[10] = '{1'b0, 1'b0, 6'd0,  32'd0, 1'b1, 1'b1, 6'd11, 32'd9,   1'b1, 1'b0, 1'b0, 6'd0,  1'b0};
        vt[11] = '{1'b0, 1'b0, 6'd0,  32'd0, 1'b1, 1'b0, 6'd11, 32'd9,   1'b1, 1'b1, 1'b1, 6'd11, 1'b1};
        vt[12] = '{1'b0, 1'b0, 6'd0,  32'd0, 1'b0, 1'b0, 6'd0,  32'd0,   1'b1, 1'b0, 1'b0, 6'd0,  1'b0};

        for (int i = 0; i < 13; i++) begin
            band_program_enable = vt[i].prog;
            band_delete_enable  = vt[i].del;
            band_program_addr   = vt[i].paddr;
            band_program_data   = vt[i].pdata;
            meter_count_valid   = vt[i].mv;
            glbl_program_en     = vt[i].glbl;
            meter_count_addr    = vt[i].maddr;
            meter_count         = vt[i].mcnt;
            evt_ready           = vt[i].rdy;
            tick();
            chk($sformatf("vec%0d_exceed_valid", i), 64'(exceed_valid), 64'(vt[i].ev));
            chk($sformatf("vec%0d_exceed_flag", i), 64'(exceed_flag), 64'(vt[i].ef));
            chk($sformatf("vec%0d_exceed_addr", i), 64'(exceed_addr), 64'(vt[i].ea));
            chk($sformatf("vec%0d_evt_valid", i), 64'(evt_valid), 64'(vt[i].evv));
            if (i == 3) begin
                chk("vec3_evt_addr", 64'(evt_addr), 64'd5);
                chk("vec3_evt_count", 64'(evt_count), 64'd3);
            end
        end

        // FIFO fill with drops, in-order drain, then retry of dropped flows.
        set_idle();
        evt_ready = 1'b0;
        for (int a = 0; a < 10; a++) begin
            set_prog(6'(a), 32'd1);
            tick();
        end
        set_idle();
        for (int a = 0; a < 10; a++) begin
            set_meter(6'(a), 32'd1);
            tick();
        end
        set_idle();
        chk("fill_drop_count", 64'(evt_drop_count), 64'd2);
        evt_ready = 1'b1;
        for (int a = 0; a < 8; a++) begin
            chk($sformatf("drain%0d_addr", a), 64'(evt_addr), 64'(a));
            chk($sformatf("drain%0d_count", a), 64'(evt_count), 64'd1);
            tick();
        end
        chk("drained_empty", 64'(evt_valid), 64'd0);
        set_meter(6'd8, 32'd2);
        tick();
        chk("retry8_addr", 64'(evt_addr), 64'd8);
        chk("retry8_count", 64'(evt_count), 64'd2);
        set_meter(6'd9, 32'd2);
        tick();
        chk("retry9_addr", 64'(evt_addr), 64'd9);
        chk("retry9_count", 64'(evt_count), 64'd2);
        set_idle();
        tick();
        chk("retry_empty", 64'(evt_valid), 64'd0);

        // Program/update collision on one flow.
        set_prog(6'd7, 32'd4);
        tick();
        set_idle();
        set_prog(6'd7, 32'd10);
        set_meter(6'd7, 32'd5);
        tick();
        chk("coll_flag", 64'(exceed_flag), 64'd1);
        chk("coll_evt_addr", 64'(evt_addr), 64'd7);
        chk("coll_evt_count", 64'(evt_count), 64'd5);
        set_idle();
        set_meter(6'd7, 32'd6);
        tick();
        chk("coll_next_flag", 64'(exceed_flag), 64'd0);
        chk("coll_next_evt", 64'(evt_valid), 64'd0);
        set_meter(6'd7, 32'd10);
        tick();
        chk("coll_rearm_flag", 64'(exceed_flag), 64'd1);
        chk("coll_rearm_evt", 64'(evt_valid), 64'd1);
        set_idle();
        tick();

        // Reset mid-operation with events queued.
        evt_ready = 1'b0;
        for (int a = 20; a < 23; a++) begin
            set_prog(6'(a), 32'd1);
            tick();
        end
        set_idle();
        for (int a = 20; a < 23; a++) begin
            set_meter(6'(a), 32'd1);
            tick();
        end
        set_idle();
        chk("pre_reset_evt", 64'(evt_valid), 64'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("post_reset_evt", 64'(evt_valid), 64'd0);
        chk("post_reset_drop", 64'(evt_drop_count), 64'd0);
        chk("post_reset_addr", 64'(evt_addr), 64'd0);
        set_meter(6'd20, 32'hFFFF_FFFF);
        tick();
        chk("post_reset_valid20", 64'(exceed_valid), 64'd1);
        chk("post_reset_flag20", 64'(exceed_flag), 64'd0);
        set_meter(6'd5, 32'hFFFF_FFFF);
        tick();
        chk("post_reset_flag5", 64'(exceed_flag), 64'd0);
        chk("post_reset_noevt", 64'(evt_valid), 64'd0);

        // Random traffic on a small address range so collisions and full-FIFO cases occur.
        set_idle();
        for (int c = 0; c < 3000; c++) begin
            reset               = ($urandom_range(0, 499) != 0);
            band_program_enable = ($urandom_range(0, 3) == 0);
            band_delete_enable  = ($urandom_range(0, 3) == 0);
            band_program_addr   = 6'($urandom_range(0, 15));
            band_program_data   = ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, 12));
            meter_count_valid   = ($urandom_range(0, 3) != 0);
            glbl_program_en     = ($urandom_range(0, 9) == 0);
            meter_count_addr    = 6'($urandom_range(0, 15));
            meter_count         = ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, 15));
            // Alternate slow and fast draining phases to reach full and empty.
            if (((c / 200) % 2) == 0) begin
                evt_ready = ($urandom_range(0, 7) == 0);
            end else begin
                evt_ready = ($urandom_range(0, 3) != 0);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
